// File: rtl/uart_cmd_parser_if.sv
// FIFO + register-bus bundle for uart_cmd_parser.
// master: parser side; slave: UART FIFOs and register file side.
interface uart_cmd_parser_if #(
  parameter int HEX_ADDR_DIGITS = 2
);
  localparam int AW = 4 * HEX_ADDR_DIGITS;

  logic [7:0]    rx_fifo_data_out;
  logic          rx_fifo_empty;
  logic          rx_fifo_read_en;
  logic [7:0]    tx_fifo_data_in;
  logic          tx_fifo_write_en;
  logic          tx_fifo_full;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata;
  logic          busy;
  logic [7:0]    err_count;

  modport master (
    input  rx_fifo_data_out,
    input  rx_fifo_empty,
    output rx_fifo_read_en,
    output tx_fifo_data_in,
    output tx_fifo_write_en,
    input  tx_fifo_full,
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata,
    output busy,
    output err_count
  );

  modport slave (
    output rx_fifo_data_out,
    output rx_fifo_empty,
    input  rx_fifo_read_en,
    input  tx_fifo_data_in,
    input  tx_fifo_write_en,
    output tx_fifo_full,
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata,
    input  busy,
    input  err_count
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII peek/poke parser: RX FIFO lines -> register bus -> TX FIFO reply.
// Ports: clock, reset_n (sync, active-low), bus (uart_cmd_parser_if.master).
module uart_cmd_parser #(
  parameter int HEX_ADDR_DIGITS = 2,
  parameter int MAX_LINE        = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  uart_cmd_parser_if.master bus
);
  localparam int AW = 4 * HEX_ADDR_DIGITS;
  localparam int LW = $clog2(MAX_LINE + 2);
  localparam int CW = $clog2(HEX_ADDR_DIGITS + 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;

  localparam logic [31:0] REP_OK = 32'h4F4B0D0A;
  localparam logic [31:0] REP_ER = 32'h45520D0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WCR,
    S_SKIP,
    S_EXEC,
    S_RDW,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    rx_byte_q;
  logic          rx_vld_q;
  logic [AW-1:0] addr_sh_q, addr_sh_d;
  logic [7:0]    data_sh_q, data_sh_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          is_wr_q, is_wr_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [31:0]   rep_q, rep_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    ecnt_q, ecnt_d;

  logic [7:0] ch;
  logic       is_cr;
  logic       is_lf;
  logic       is_hex;
  logic [3:0] nib;
  logic       rx_state;
  logic       pop;
  logic       over;

  function automatic logic [7:0] hex_ch(
    input logic [3:0] n
  );
    return (n < 4'd10) ? (8'h30 + {4'h0, n})
                       : (8'h37 + {4'h0, n});
  endfunction

  // Upper-case the byte and classify it.
  always_comb begin
    ch = rx_byte_q;
    if (rx_byte_q >= 8'h61 && rx_byte_q <= 8'h7A)
      ch = rx_byte_q - 8'h20;
    is_cr  = (ch == CH_CR);
    is_lf  = (ch == CH_LF);
    is_hex = 1'b0;
    nib    = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nib    = 4'(ch - 8'h30);
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(ch - 8'h37);
    end
  end

  // rx_vld_q doubles as the pop strobe and the one-cycle pop gap.
  assign rx_state = (state_q == S_IDLE) ||
                    (state_q == S_ADDR) ||
                    (state_q == S_DATA) ||
                    (state_q == S_WCR)  ||
                    (state_q == S_SKIP);
  assign pop = rx_state && !rx_vld_q &&
               !bus.rx_fifo_empty;

  always_comb begin
    state_d   = state_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    rep_d     = rep_q;
    idx_d     = idx_q;
    ecnt_d    = ecnt_q;
    over      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_vld_q && !is_lf) begin
          unique case (1'b1)
            is_cr: ;
            (ch == CH_W || ch == CH_R): begin
              is_wr_d = (ch == CH_W);
              cnt_d   = '0;
              state_d = S_ADDR;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (rx_vld_q && !is_lf) begin
          unique case (1'b1)
            is_cr: begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end
            is_hex: begin
              addr_sh_d = AW'({addr_sh_q, nib});
              if (cnt_q == CW'(HEX_ADDR_DIGITS - 1)) begin
                cnt_d   = '0;
                state_d = is_wr_q ? S_DATA : S_WCR;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end
          endcase
        end
      end
      S_DATA: begin
        if (rx_vld_q && !is_lf) begin
          unique case (1'b1)
            is_cr: begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end
            is_hex: begin
              data_sh_d = {data_sh_q[3:0], nib};
              if (cnt_q == CW'(1)) begin
                cnt_d   = '0;
                state_d = S_WCR;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end
          endcase
        end
      end
      S_WCR: begin
        if (rx_vld_q && !is_lf) begin
          if (is_cr) begin
            if (err_q) begin
              state_d = S_RESP;
            end else begin
              // Bus fields update only for a clean line.
              addr_d = addr_sh_q;
              if (is_wr_q)
                wdata_d = data_sh_q;
              state_d = S_EXEC;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (rx_vld_q && is_cr)
          state_d = S_RESP;
      end
      S_EXEC: begin
        state_d = is_wr_q ? S_RESP : S_RDW;
      end
      S_RDW: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (!bus.tx_fifo_full) begin
          rep_d = {rep_q[23:0], 8'h00};
          idx_d = idx_q + 1'b1;
          if (idx_q == 2'd3) begin
            err_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
    endcase

    // Line length guard on every printable byte.
    if (rx_vld_q && !is_lf && !is_cr) begin
      if (len_q != LW'(MAX_LINE + 1))
        len_d = len_q + 1'b1;
      over = (len_q >= LW'(MAX_LINE));
      if (over) begin
        err_d   = 1'b1;
        state_d = S_SKIP;
      end
    end

    // Reply is chosen once, on entry to RESP.
    if (state_d == S_RESP && state_q != S_RESP) begin
      idx_d = 2'd0;
      if (err_d) begin
        rep_d = REP_ER;
        if (ecnt_q != 8'hFF)
          ecnt_d = ecnt_q + 1'b1;
      end else if (state_q == S_RDW) begin
        rep_d = {hex_ch(bus.reg_rdata[7:4]),
                 hex_ch(bus.reg_rdata[3:0]),
                 CH_CR, CH_LF};
      end else begin
        rep_d = REP_OK;
      end
    end

    if (state_d == S_IDLE) begin
      len_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rx_byte_q <= 8'h00;
      rx_vld_q  <= 1'b0;
      addr_sh_q <= '0;
      data_sh_q <= 8'h00;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      is_wr_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      rep_q     <= 32'h0;
      idx_q     <= 2'd0;
      ecnt_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      rx_vld_q  <= pop;
      if (pop)
        rx_byte_q <= bus.rx_fifo_data_out;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      idx_q     <= idx_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign bus.rx_fifo_read_en  = rx_vld_q;
  assign bus.tx_fifo_write_en = (state_q == S_RESP) &&
                                !bus.tx_fifo_full;
  assign bus.tx_fifo_data_in  = (state_q == S_RESP) ?
                                rep_q[31:24] : 8'h00;
  assign bus.reg_addr         = addr_q;
  assign bus.reg_wdata        = wdata_q;
  assign bus.reg_we           = (state_q == S_EXEC) && is_wr_q;
  assign bus.reg_re           = (state_q == S_EXEC) && !is_wr_q;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.err_count        = ecnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser.
// Models the RX FIFO, logs TX pushes and bus strobes.
module tb_uart_cmd_parser;
  logic clock = 1'b0;
  logic reset_n;

  uart_cmd_parser_if #(.HEX_ADDR_DIGITS(2)) ifc();

  uart_cmd_parser #(
    .HEX_ADDR_DIGITS(2),
    .MAX_LINE(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(ifc)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx_mem [512];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic [7:0] tx_log [$];
  int we_cnt = 0;
  int re_cnt = 0;
  int both_cnt = 0;
  int wr_full = 0;
  int hold_rd = 0;
  int hold_wr = 0;
  logic hold = 1'b0;
  logic [7:0] we_addr = 8'h00;
  logic [7:0] we_data = 8'h00;
  logic [7:0] re_addr = 8'h00;

  // FIFO model and monitor; stimulus changes at posedge+1.
  always @(negedge clock) begin
    if (ifc.tx_fifo_write_en) begin
      tx_log.push_back(ifc.tx_fifo_data_in);
      if (ifc.tx_fifo_full) wr_full++;
    end
    if (ifc.reg_we) begin
      we_cnt++;
      we_addr = ifc.reg_addr;
      we_data = ifc.reg_wdata;
    end
    if (ifc.reg_re) begin
      re_cnt++;
      re_addr = ifc.reg_addr;
    end
    if (ifc.reg_we && ifc.reg_re) both_cnt++;
    if (hold && ifc.rx_fifo_read_en) hold_rd++;
    if (hold && ifc.tx_fifo_write_en) hold_wr++;
    if (ifc.rx_fifo_read_en && rd_ptr != wr_ptr)
      rd_ptr = rd_ptr + 1;
    ifc.rx_fifo_empty = (rd_ptr == wr_ptr);
    ifc.rx_fifo_data_out =
      (rd_ptr == wr_ptr) ? 8'h00 : rx_mem[rd_ptr];
  end

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    rx_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(rd_ptr == wr_ptr && !ifc.busy &&
             !ifc.rx_fifo_read_en) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check({tag, "_timeout"}, 32'd1, 32'd0);
    tick();
  endtask

  function automatic logic [31:0] reply(input int base);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (base + i < tx_log.size())
        r = {r[23:0], tx_log[base + i]};
      else
        r = {r[23:0], 8'h00};
    end
    return r;
  endfunction

  int b;
  int w0;
  int r0;
  int n;

  initial begin
    reset_n = 1'b0;
    ifc.tx_fifo_full = 1'b0;
    ifc.reg_rdata = 8'h00;
    repeat (3) tick();
    check("rst_busy", 32'(ifc.busy), 0);
    check("rst_errc", 32'(ifc.err_count), 0);
    check("rst_addr", 32'(ifc.reg_addr), 0);
    check("rst_strb", {ifc.reg_we, ifc.reg_re,
      ifc.rx_fifo_read_en, ifc.tx_fifo_write_en}, 0);
    reset_n = 1'b1;
    tick();

    // Write command.
    b = tx_log.size(); w0 = we_cnt; r0 = re_cnt;
    send("W1A5C"); put(8'h0D);
    wait_done("wr");
    check("wr_we", 32'(we_cnt - w0), 1);
    check("wr_re", 32'(re_cnt - r0), 0);
    check("wr_addr", 32'(we_addr), 32'h1A);
    check("wr_data", 32'(we_data), 32'h5C);
    check("wr_rep", reply(b), 32'h4F4B0D0A);
    check("wr_ntx", 32'(tx_log.size() - b), 4);
    check("wr_errc", 32'(ifc.err_count), 0);

    // Lower-case read.
    ifc.reg_rdata = 8'h3F;
    b = tx_log.size(); w0 = we_cnt; r0 = re_cnt;
    send("r1a"); put(8'h0D);
    wait_done("rd");
    check("rd_re", 32'(re_cnt - r0), 1);
    check("rd_we", 32'(we_cnt - w0), 0);
    check("rd_addr", 32'(re_addr), 32'h1A);
    check("rd_rep", reply(b), 32'h33460D0A);
    check("rd_ntx", 32'(tx_log.size() - b), 4);

    // Bad hex digit, then a clean read.
    b = tx_log.size(); w0 = we_cnt; r0 = re_cnt;
    send("W1G00"); put(8'h0D); put(8'h0A);
    wait_done("bad");
    check("bad_strb", 32'(we_cnt - w0 + re_cnt - r0), 0);
    check("bad_rep", reply(b), 32'h45520D0A);
    check("bad_ntx", 32'(tx_log.size() - b), 4);
    check("bad_errc", 32'(ifc.err_count), 1);
    check("bad_hold", 32'(ifc.reg_addr), 32'h1A);
    ifc.reg_rdata = 8'hA7;
    b = tx_log.size(); r0 = re_cnt;
    send("R00"); put(8'h0D);
    wait_done("r00");
    check("r00_re", 32'(re_cnt - r0), 1);
    check("r00_addr", 32'(re_addr), 32'h00);
    check("r00_rep", reply(b), 32'h41370D0A);

    // Over-long line.
    b = tx_log.size(); w0 = we_cnt; r0 = re_cnt;
    for (int i = 0; i < 20; i++) put(8'h41);
    put(8'h0D);
    wait_done("long");
    check("long_rep", reply(b), 32'h45520D0A);
    check("long_ntx", 32'(tx_log.size() - b), 4);
    check("long_drain", 32'(wr_ptr - rd_ptr), 0);
    check("long_strb", 32'(we_cnt - w0 + re_cnt - r0), 0);
    check("long_errc", 32'(ifc.err_count), 2);

    // TX FIFO full during a read reply.
    ifc.reg_rdata = 8'h5E;
    ifc.tx_fifo_full = 1'b1;
    b = tx_log.size(); r0 = re_cnt;
    send("R05"); put(8'h0D);
    n = 0;
    while (rd_ptr != wr_ptr && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check("full_timeout", 32'd1, 32'd0);
    tick();
    hold = 1'b1;
    put(8'h0A);
    repeat (50) tick();
    check("full_busy", 32'(ifc.busy), 1);
    hold = 1'b0;
    ifc.tx_fifo_full = 1'b0;
    wait_done("full");
    check("full_rd", 32'(hold_rd), 0);
    check("full_wr", 32'(hold_wr), 0);
    check("full_re", 32'(re_cnt - r0), 1);
    check("full_rep", reply(b), 32'h35450D0A);
    check("full_ntx", 32'(tx_log.size() - b), 4);
    check("full_drain", 32'(wr_ptr - rd_ptr), 0);

    // Reset in the middle of a line.
    send("W12");
    n = 0;
    while ((rd_ptr != wr_ptr || ifc.rx_fifo_read_en)
           && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check("mid_timeout", 32'd1, 32'd0);
    tick();
    check("mid_busy", 32'(ifc.busy), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rbusy", 32'(ifc.busy), 0);
    check("mid_raddr", 32'(ifc.reg_addr), 0);
    check("mid_rwdat", 32'(ifc.reg_wdata), 0);
    check("mid_rerrc", 32'(ifc.err_count), 0);
    check("mid_rtx", 32'(ifc.tx_fifo_data_in), 0);
    b = tx_log.size();
    repeat (5) tick();
    check("mid_notx", 32'(tx_log.size() - b), 0);
    b = tx_log.size(); w0 = we_cnt;
    send("W1234"); put(8'h0D);
    wait_done("post");
    check("post_we", 32'(we_cnt - w0), 1);
    check("post_addr", 32'(we_addr), 32'h12);
    check("post_data", 32'(we_data), 32'h34);
    check("post_rep", reply(b), 32'h4F4B0D0A);

    check("both_strb", 32'(both_cnt), 0);
    check("wr_when_full", 32'(wr_full), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
